// File: rtl/countdown_timer_pkg.sv
// Shared types, limits and BCD helpers for the countdown timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int         BCD_W    = 4;
  localparam logic [6:0] MAX_SECS = 7'd99;

  // Clamps to MAX_SECS, then splits into {tens, ones} BCD digits.
  function automatic logic [2*BCD_W-1:0] bin_to_bcd(input logic [6:0] v);
    logic [6:0] c;
    c = (v > MAX_SECS) ? MAX_SECS : v;
    return {4'(c / 7'd10), 4'(c % 7'd10)};
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [BCD_W-1:0] tens,
                                            input logic [BCD_W-1:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

// File: rtl/countdown_timer_bcd2_dec.sv
// Combinational 2-digit BCD decrement, saturating at 00.
// Zero latency; no flow control.
module countdown_timer_bcd2_dec
  import countdown_timer_pkg::*;
(
  input  logic [BCD_W-1:0] tens,
  input  logic [BCD_W-1:0] ones,
  output logic [BCD_W-1:0] tens_nxt,
  output logic [BCD_W-1:0] ones_nxt,
  output logic             is_zero_next
);

  always_comb begin
    tens_nxt = tens;
    ones_nxt = ones;
    if (ones != 4'd0) begin
      ones_nxt = ones - 4'd1;
    end else if (tens != 4'd0) begin
      // Borrow from the tens digit.
      tens_nxt = tens - 4'd1;
      ones_nxt = 4'd9;
    end
    is_zero_next = (tens_nxt == 4'd0) && (ones_nxt == 4'd0);
  end

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD game countdown timer driven by a 1 s tick from the divider.
// All outputs registered (tick -> digits in 1 cycle); no backpressure.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int LOW_TIME_SECS = 10
) (
  input  logic       default_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic [6:0] load_value,
  input  logic       tick,
  output logic       tick_enable,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       running,
  output logic       low_time,
  output logic       expired,
  output logic       done
);

  state_t             state, nxt_state;
  logic               pause_q;
  logic               pause_rise;
  logic [BCD_W-1:0]   dec_tens, dec_ones;
  logic               dec_zero;
  logic [BCD_W-1:0]   nxt_tens, nxt_ones;
  logic [2*BCD_W-1:0] load_bcd;
  logic               done_nxt;
  logic               low_nxt;

  assign pause_rise = pause && !pause_q;
  assign load_bcd   = bin_to_bcd(load_value);

  countdown_timer_bcd2_dec u_dec (
    .tens         (secs_tens),
    .ones         (secs_ones),
    .tens_nxt     (dec_tens),
    .ones_nxt     (dec_ones),
    .is_zero_next (dec_zero)
  );

  // Priority: start > tick > pause edge.
  always_comb begin
    nxt_state = state;
    nxt_tens  = secs_tens;
    nxt_ones  = secs_ones;
    done_nxt  = 1'b0;
    if (start) begin
      nxt_tens = load_bcd[2*BCD_W-1:BCD_W];
      nxt_ones = load_bcd[BCD_W-1:0];
      if (load_bcd == '0) begin
        nxt_state = ST_EXPIRED;
        done_nxt  = 1'b1;
      end else begin
        nxt_state = ST_RUN;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (tick) begin
            nxt_tens = dec_tens;
            nxt_ones = dec_ones;
          end
          if (tick && dec_zero) begin
            nxt_state = ST_EXPIRED;
            done_nxt  = 1'b1;
          end else if (pause_rise) begin
            nxt_state = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (pause_rise) nxt_state = ST_RUN;
        end
        default: ;
      endcase
    end
    low_nxt = ((nxt_state == ST_RUN) || (nxt_state == ST_PAUSED)) &&
              (bcd_to_bin(nxt_tens, nxt_ones) <= 7'(LOW_TIME_SECS));
  end

  always_ff @(posedge default_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pause_q     <= 1'b0;
      secs_tens   <= '0;
      secs_ones   <= '0;
      tick_enable <= 1'b0;
      running     <= 1'b0;
      low_time    <= 1'b0;
      expired     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= nxt_state;
      pause_q     <= pause;
      secs_tens   <= nxt_tens;
      secs_ones   <= nxt_ones;
      tick_enable <= (nxt_state == ST_RUN);
      running     <= (nxt_state == ST_RUN);
      low_time    <= low_nxt;
      expired     <= (nxt_state == ST_EXPIRED);
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares.
module tb_countdown_timer;

  logic       default_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [6:0] load_value = '0;
  logic       tick = 1'b0;
  logic       tick_enable;
  logic [3:0] secs_tens, secs_ones;
  logic       running, low_time, expired, done;

  countdown_timer #(.LOW_TIME_SECS(10)) dut (
    .default_clk (default_clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .load_value  (load_value),
    .tick        (tick),
    .tick_enable (tick_enable),
    .secs_tens   (secs_tens),
    .secs_ones   (secs_ones),
    .running     (running),
    .low_time    (low_time),
    .expired     (expired),
    .done        (done)
  );

  always #5 default_clk = ~default_clk;

  // Reference model: remaining seconds as an integer plus a mode code
  // (0 idle, 1 counting, 2 paused, 3 expired).
  int  m_mode = 0;
  int  m_rem  = 0;
  bit  m_prev_pause = 1'b0;
  bit  m_done = 1'b0;

  logic [12:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          passes = 0;
  bit          cur_pause = 1'b0;

  function automatic logic [12:0] model_outputs();
    logic [3:0] t, o;
    bit low;
    t   = 4'(m_rem / 10);
    o   = 4'(m_rem % 10);
    low = ((m_mode == 1) || (m_mode == 2)) && (m_rem <= 10);
    return {t, o, (m_mode == 1), (m_mode == 1), low, (m_mode == 3), m_done};
  endfunction

  task automatic model_step(input bit r, input bit s, input bit p,
                            input bit t, input int lv);
    bit edge_seen;
    if (r) begin
      m_mode = 0; m_rem = 0; m_prev_pause = 1'b0; m_done = 1'b0;
    end else begin
      edge_seen    = p && !m_prev_pause;
      m_prev_pause = p;
      m_done       = 1'b0;
      if (s) begin
        m_rem = (lv > 99) ? 99 : lv;
        if (m_rem == 0) begin m_mode = 3; m_done = 1'b1; end
        else m_mode = 1;
      end else if (m_mode == 1) begin
        if (t) m_rem = m_rem - 1;
        if (m_rem == 0) begin m_mode = 3; m_done = 1'b1; end
        else if (edge_seen) m_mode = 2;
      end else if (m_mode == 2 && edge_seen) begin
        m_mode = 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit p, input bit t,
                     input int lv, input string tag);
    @(negedge default_clk);
    reset = r; start = s; pause = p; tick = t; load_value = 7'(lv);
    model_step(r, s, p, t, lv);
    exp_q.push_back(model_outputs());
    tag_q.push_back(tag);
  endtask

  // Monitor: one expectation per clock, compared just after the edge.
  initial begin
    logic [12:0] got, expv;
    string tag;
    forever begin
      @(posedge default_clk);
      #1;
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        tag  = tag_q.pop_front();
        got  = {secs_tens, secs_ones, running, tick_enable, low_time, expired, done};
        checks++;
        if (got === expv) passes++;
        else $display("FAIL %s: got t/o=%0d/%0d run=%b te=%b low=%b exp=%b done=%b, required t/o=%0d/%0d run=%b te=%b low=%b exp=%b done=%b",
                      tag, got[12:9], got[8:5], got[4], got[3], got[2], got[1], got[0],
                      expv[12:9], expv[8:5], expv[4], expv[3], expv[2], expv[1], expv[0]);
      end
    end
  end

  initial begin
    int r, s, t, lv;
    cyc(1, 0, 0, 0, 0, "reset_state");
    cyc(1, 0, 0, 0, 0, "reset_state");

    // Reset mid-count at 37.
    cyc(0, 1, 0, 0, 37, "t1_load37");
    cyc(0, 0, 0, 0, 0,  "t1_run37");
    cyc(1, 0, 0, 0, 0,  "t1_reset_mid_run");
    cyc(0, 0, 0, 0, 0,  "t1_idle_after");

    // Borrow through 10 -> 09.
    cyc(0, 1, 0, 0, 12, "t2_load12");
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, "t2_tick");
      cyc(0, 0, 0, 0, 0, "t2_hold");
    end

    // Expiry with a single done pulse.
    cyc(0, 1, 0, 0, 2, "t3_load2");
    cyc(0, 0, 0, 1, 0, "t3_tick_01");
    cyc(0, 0, 0, 1, 0, "t3_tick_00_done");
    cyc(0, 0, 0, 0, 0, "t3_done_drops");
    cyc(0, 0, 0, 1, 0, "t3_tick_ignored");

    // Clamp and zero load.
    cyc(0, 1, 0, 0, 120, "t4_clamp99");
    cyc(0, 0, 0, 0, 0,   "t4_hold99");
    cyc(0, 1, 0, 0, 0,   "t4_load0_done");
    cyc(0, 0, 0, 0, 0,   "t4_expired_hold");
    cyc(0, 1, 0, 0, 127, "t4_clamp127");

    // Pause holds the count; second edge resumes.
    cyc(0, 1, 0, 0, 15, "t5_load15");
    cyc(0, 0, 1, 0, 0,  "t5_pause_edge");
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0, "t5_paused_tick");
    cyc(0, 0, 0, 1, 0,  "t5_paused_release");
    cyc(0, 0, 1, 0, 0,  "t5_resume_edge");
    cyc(0, 0, 1, 1, 0,  "t5_resumed_tick");
    cyc(0, 0, 0, 1, 0,  "t5_tick_with_edge_prep");
    cyc(0, 0, 1, 1, 0,  "t5_tick_and_edge");

    // Start beats tick; low_time threshold.
    cyc(0, 1, 0, 0, 40, "t6_load40");
    cyc(0, 1, 0, 1, 25, "t6_start_tick_25");
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 1, 0, "t6_count_to_11");
    cyc(0, 0, 0, 0, 0,  "t6_at11_not_low");
    cyc(0, 0, 0, 1, 0,  "t6_at10_low");

    // Randomized traffic.
    cur_pause = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 29) == 0);
      t  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) cur_pause = ~cur_pause;
      lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12);
      cyc(r[0], s[0], cur_pause, t[0], lv, "rand");
    end

    cyc(0, 0, 0, 0, 0, "final");
    @(posedge default_clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
